// File: rtl/apb_pkg.sv
// Shared FSM encoding, default sizing and the command entry layout
// for the APB request sequencer.
package apb_pkg;

    localparam int DEPTH_DEF   = 4;
    localparam int TIMEOUT_DEF = 16;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

endpackage

// File: rtl/apb_req_sequencer_if.sv
// Command, APB request and response channels of the sequencer.
// master is the sequencer side, slave the host/APB side.
interface apb_req_sequencer_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;

    logic        transfer;
    logic        PWRITE;
    logic [31:0] APB_write_ADDRESS;
    logic [31:0] APB_read_ADDRESS;
    logic [31:0] APB_DATA;
    logic        xfer_done;
    logic [31:0] APB_read_data_out;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_write;
    logic        rsp_err;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  xfer_done, APB_read_data_out, rsp_ready,
        output cmd_ready, transfer, PWRITE,
        output APB_write_ADDRESS, APB_read_ADDRESS, APB_DATA,
        output rsp_valid, rsp_rdata, rsp_write, rsp_err
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output xfer_done, APB_read_data_out, rsp_ready,
        input  cmd_ready, transfer, PWRITE,
        input  APB_write_ADDRESS, APB_read_ADDRESS, APB_DATA,
        input  rsp_valid, rsp_rdata, rsp_write, rsp_err
    );

endinterface

// File: rtl/apb_cmd_fifo.sv
// Synchronous command FIFO, 65-bit entries, registered occupancy count.
// Head entry is presented combinationally on dout.
module apb_cmd_fifo
    import apb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic pop,
    input  cmd_t din,
    output cmd_t dout,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    cmd_t          mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          wr_en;
    logic          rd_en;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign dout  = mem[rptr];
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr] <= din;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_en) wptr <= wptr + AW'(1);
            if (rd_en) rptr <= rptr + AW'(1);
            if (wr_en && !rd_en)
                count <= count + (AW+1)'(1);
            else if (rd_en && !wr_en)
                count <= count - (AW+1)'(1);
        end
    end

endmodule

// File: rtl/apb_req_sequencer.sv
// Queues host commands and sequences them one at a time onto an APB
// master request port, returning one response per command in order.
module apb_req_sequencer
    import apb_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input logic                 PCLK,
    input logic                 PRESETn,
    apb_req_sequencer_if.master bus
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    cmd_t          cmd_in;
    cmd_t          head;

    logic          wr_q;
    logic [31:0]   waddr_q;
    logic [31:0]   raddr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q;
    logic          rwr_q;
    logic          err_q;

    assign cmd_in = {bus.cmd_write, bus.cmd_addr, bus.cmd_wdata};
    assign push   = bus.cmd_valid && !full;
    assign pop    = (state == S_IDLE) && !empty;

    apb_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .push  (push),
        .pop   (pop),
        .din   (cmd_in),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign bus.cmd_ready         = !full;
    assign bus.transfer          = (state == S_ISSUE) ||
                                   (state == S_WAIT);
    assign bus.PWRITE            = wr_q;
    assign bus.APB_write_ADDRESS = waddr_q;
    assign bus.APB_read_ADDRESS  = raddr_q;
    assign bus.APB_DATA          = wdata_q;
    assign bus.rsp_valid         = (state == S_RESP);
    assign bus.rsp_rdata         = rdata_q;
    assign bus.rsp_write         = rwr_q;
    assign bus.rsp_err           = err_q;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state   <= S_IDLE;
            cnt     <= '0;
            wr_q    <= 1'b0;
            waddr_q <= '0;
            raddr_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rwr_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (pop) begin
                        wr_q    <= head.write;
                        waddr_q <= head.write ? head.addr : '0;
                        raddr_q <= head.write ? '0 : head.addr;
                        wdata_q <= head.write ? head.wdata : '0;
                        state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.xfer_done) begin
                        rdata_q <= wr_q ? '0 : bus.APB_read_data_out;
                        rwr_q   <= wr_q;
                        err_q   <= 1'b0;
                        state   <= S_RESP;
                    end else if (cnt == CNT_LAST) begin
                        rdata_q <= '0;
                        rwr_q   <= wr_q;
                        err_q   <= 1'b1;
                        state   <= S_RESP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
